// File: rtl/issue_queue_ctrl.sv
// issue_queue_ctrl: issue-queue slot allocation, wakeup, branch kill and oldest-ready select
module issue_queue_ctrl #(
  parameter int NUM_SLOTS  = 8,
  parameter int PREG_W     = 7,
  parameter int BRMASK_W   = 12,
  parameter int NUM_WAKEUP = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dis_valid,
  output logic                         dis_ready,
  input  logic [6:0]                   dis_uopc,
  input  logic [PREG_W-1:0]            dis_pdst,
  input  logic [PREG_W-1:0]            dis_prs1,
  input  logic [PREG_W-1:0]            dis_prs2,
  input  logic                         dis_prs1_busy,
  input  logic                         dis_prs2_busy,
  input  logic [BRMASK_W-1:0]          dis_br_mask,
  input  logic [NUM_WAKEUP-1:0]        wb_valid,
  input  logic [NUM_WAKEUP*PREG_W-1:0] wb_pdst,
  input  logic                         br_valid,
  input  logic                         br_mispredict,
  input  logic [BRMASK_W-1:0]          br_mask,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output logic [6:0]                   iss_uopc,
  output logic [PREG_W-1:0]            iss_pdst,
  output logic [PREG_W-1:0]            iss_prs1,
  output logic [PREG_W-1:0]            iss_prs2,
  output logic [BRMASK_W-1:0]          iss_br_mask,
  output logic [$clog2(NUM_SLOTS):0]   occupancy
);
  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int OCC_W = IDX_W + 1;

  typedef enum logic [1:0] {FREE = 2'd0, WAIT = 2'd1, RDY = 2'd2} slot_st_e;

  typedef struct packed {
    logic [6:0]          uopc;
    logic [PREG_W-1:0]   pdst;
    logic [PREG_W-1:0]   prs1;
    logic [PREG_W-1:0]   prs2;
    logic                b1;
    logic                b2;
    logic [BRMASK_W-1:0] br_mask;
  } slot_t;

  slot_st_e             st_q    [NUM_SLOTS];
  slot_st_e             st_d    [NUM_SLOTS];
  slot_t                slot_q  [NUM_SLOTS];
  slot_t                slot_d  [NUM_SLOTS];
  // older_q[i][j] set means slot i was written before slot j; only meaningful between live slots
  logic [NUM_SLOTS-1:0] older_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] older_d [NUM_SLOTS];

  logic                 alloc_hit;
  logic [IDX_W-1:0]     alloc_idx;
  logic [OCC_W-1:0]     occ;
  logic [NUM_SLOTS-1:0] kill;
  logic [NUM_SLOTS-1:0] cand;
  logic [NUM_SLOTS-1:0] beaten;
  logic [IDX_W-1:0]     sel_idx;
  logic [BRMASK_W-1:0]  rsv_clr;
  logic                 dis_fire;
  slot_t                dis_slot;

  function automatic logic woken(input logic [PREG_W-1:0] tag, input logic [NUM_WAKEUP-1:0] v,
                                 input logic [NUM_WAKEUP*PREG_W-1:0] tags);
    logic h;
    h = 1'b0;
    for (int p = 0; p < NUM_WAKEUP; p++) h = h | (v[p] & (tags[p*PREG_W +: PREG_W] == tag));
    return h;
  endfunction

  assign rsv_clr   = (br_valid & ~br_mispredict) ? br_mask : '0;
  assign dis_ready = alloc_hit;
  assign occupancy = occ;

  // lowest-index free slot for allocation and live-slot count, both from registered state
  always_comb begin
    alloc_hit = 1'b0;
    alloc_idx = '0;
    occ = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (st_q[i] == FREE) begin
        alloc_hit = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) occ = occ + {{IDX_W{1'b0}}, st_q[i] != FREE};
  end

  // oldest ready slot not being killed this cycle is the one offered
  always_comb begin
    kill = '0;
    cand = '0;
    beaten = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      kill[i] = br_valid & br_mispredict & (st_q[i] != FREE) & (|(slot_q[i].br_mask & br_mask));
      cand[i] = (st_q[i] == RDY) & ~kill[i];
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = 0; j < NUM_SLOTS; j++) beaten[i] = beaten[i] | (cand[j] & older_q[j][i]);
      if (cand[i] && !beaten[i]) sel_idx = IDX_W'(i);
    end
  end

  assign iss_valid   = |cand;
  assign iss_uopc    = iss_valid ? slot_q[sel_idx].uopc : '0;
  assign iss_pdst    = iss_valid ? slot_q[sel_idx].pdst : '0;
  assign iss_prs1    = iss_valid ? slot_q[sel_idx].prs1 : '0;
  assign iss_prs2    = iss_valid ? slot_q[sel_idx].prs2 : '0;
  assign iss_br_mask = iss_valid ? (slot_q[sel_idx].br_mask & ~rsv_clr) : '0;

  // per-slot next state: wakeup, branch clear, kill/issue free, then write of the dispatching uop
  always_comb begin
    dis_fire = dis_valid & alloc_hit & ~(br_valid & br_mispredict & (|(dis_br_mask & br_mask)));
    dis_slot.uopc = dis_uopc;
    dis_slot.pdst = dis_pdst;
    dis_slot.prs1 = dis_prs1;
    dis_slot.prs2 = dis_prs2;
    dis_slot.b1 = dis_prs1_busy & ~woken(dis_prs1, wb_valid, wb_pdst);
    dis_slot.b2 = dis_prs2_busy & ~woken(dis_prs2, wb_valid, wb_pdst);
    dis_slot.br_mask = dis_br_mask & ~rsv_clr;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      slot_d[i].b1 = slot_q[i].b1 & ~woken(slot_q[i].prs1, wb_valid, wb_pdst);
      slot_d[i].b2 = slot_q[i].b2 & ~woken(slot_q[i].prs2, wb_valid, wb_pdst);
      slot_d[i].br_mask = slot_q[i].br_mask & ~rsv_clr;
      older_d[i] = older_q[i];
      st_d[i] = st_q[i];
      if (kill[i] || (iss_valid && iss_ready && sel_idx == IDX_W'(i))) st_d[i] = FREE;
      else if (st_q[i] == WAIT && !slot_d[i].b1 && !slot_d[i].b2) st_d[i] = RDY;
    end
    if (dis_fire) begin
      slot_d[alloc_idx] = dis_slot;
      if (dis_slot.b1 || dis_slot.b2) st_d[alloc_idx] = WAIT;
      else st_d[alloc_idx] = RDY;
      for (int j = 0; j < NUM_SLOTS; j++) older_d[j][alloc_idx] = 1'b1;
      older_d[alloc_idx] = '0;
    end
  end

  // slot state, payload and age matrix registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i] <= FREE;
        slot_q[i] <= '0;
        older_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i] <= st_d[i];
        slot_q[i] <= slot_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end
endmodule

// File: doc/issue_queue_ctrl.md
Name: issue_queue_ctrl

Overview:
Controls an issue queue of NUM_SLOTS micro-op slots between rename/dispatch and one execution pipe. Each cycle it allocates an incoming uop to a free slot and wakes operands from writeback tags. It applies branch resolution and kill to every slot. It selects the oldest ready slot for issue over a valid/ready handshake.

Parameters:
NUM_SLOTS, 8, number of issue slots (≥2)
PREG_W, 7, physical register tag width
BRMASK_W, 12, branch mask width
NUM_WAKEUP, 2, writeback wakeup ports

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
dis_valid  in  1  dispatch uop valid
dis_ready  out  1  a free slot exists
dis_uopc  in  7  micro-op code
dis_pdst  in  PREG_W  destination tag
dis_prs1  in  PREG_W  source 1 tag
dis_prs2  in  PREG_W  source 2 tag
dis_prs1_busy  in  1  source 1 not yet written
dis_prs2_busy  in  1  source 2 not yet written
dis_br_mask  in  BRMASK_W  unresolved branches the uop depends on
wb_valid  in  NUM_WAKEUP  wakeup valid per port
wb_pdst  in  NUM_WAKEUP*PREG_W  wakeup tags, port i at bits [i*PREG_W +: PREG_W]
br_valid  in  1  branch resolved this cycle
br_mispredict  in  1  resolution is a mispredict
br_mask  in  BRMASK_W  one-hot tag of the resolved branch
iss_valid  out  1  a uop is offered for issue
iss_ready  in  1  execution pipe accepts
iss_uopc  out  7  issued fields, zero when iss_valid=0
iss_pdst  out  PREG_W
iss_prs1  out  PREG_W
iss_prs2  out  PREG_W
iss_br_mask  out  BRMASK_W
occupancy  out  $clog2(NUM_SLOTS)+1  number of non-FREE slots

Behaviour:
- Reset (async, any time, including mid-dispatch/issue): all slots FREE, age state cleared, dis_ready=1, iss_valid=0, all iss_* fields=0, occupancy=0.
- Per-slot state machine:
  - FREE -> WAIT: dispatch written with any busy bit.
  - FREE -> RDY: dispatch written with both busy bits clear.
  - WAIT -> RDY: last busy bit clears.
  - RDY -> FREE: issue handshake.
  - Any -> FREE: kill.
- Dispatch accept = dis_valid & dis_ready.
  - dis_ready comes from registered state only: a slot freed by issue or kill this cycle is usable next cycle.
  - Allocation picks the lowest-index FREE slot.
  - The new slot is youngest in age order.
- Wakeup: a source tag equal to any wb_pdst with wb_valid set clears its busy bit at the clock edge.
  - Applies to stored slots and to the uop dispatching in the same cycle.
  - A slot woken at edge N is RDY and can be offered in cycle N+1.
- Select: iss_valid=1 iff some RDY slot is not being killed this cycle.
  - The offered slot is the oldest such slot; iss_* are driven combinationally from it.
  - When iss_valid & iss_ready, that slot goes FREE at the edge.
  - If iss_ready=0, the offer may change next cycle only if an older slot becomes RDY.
- Branch, br_valid & ~br_mispredict: clear the br_mask bit from every slot and from the dispatching uop.
  - If the issuing slot has that bit set, iss_br_mask shows it cleared in the same cycle.
- Branch, br_valid & br_mispredict: every slot whose mask ANDed with br_mask is non-zero goes FREE.
  - A dispatching uop with that bit set is accepted but not written.
  - Kill beats issue: a killed slot is never offered in that cycle.
- Simultaneous dispatch, issue, kill and wakeup are all legal in one cycle.
- occupancy updates with the edge: +1 for a written dispatch, −1 per freed slot.
- Full (occupancy=NUM_SLOTS): dis_ready=0; dis_valid is ignored.
- Empty: iss_valid=0.
- The age order stays correct across arbitrary free/reallocate patterns; there is no wrap ambiguity.

Test Plan:
1. Reset then dispatch uopc=0x13, pdst=5, prs1=1, prs2=2, both busy clear -> iss_valid=1 next cycle with iss_pdst=5; with iss_ready=1, occupancy returns to 0 after the edge.
2. Dispatch A (prs1=9 busy) then B (ready); wb_valid[0]=1, wb_pdst=9 -> B issues first; A is offered the cycle after the wakeup edge.
3. Dispatch uop with prs2=12 busy while wb_valid[1]=1, wb_pdst=12 in the same cycle -> slot enters RDY; iss_valid=1 the next cycle.
4. Fill 8 slots, all busy -> dis_ready=0 and occupancy=8; a 9th dis_valid is dropped; wake one slot and issue it -> dis_ready=1 one cycle after the issue edge.
5. Slots with br_mask 0x001, 0x002, 0x003; br_valid=1, br_mispredict=1, br_mask=0x001 -> slots 0 and 2 FREE, occupancy=1; then br_mispredict=0, br_mask=0x002 -> remaining slot shows iss_br_mask=0x000.
6. Assert rst while 3 slots are valid and iss_valid=1 -> iss_valid, occupancy and iss_* go to 0 immediately, dis_ready=1.
